// File: rtl/cdc_handshake_tx_if.sv
// Bundles the local valid/ready side and the far-domain req/ack side of the CDC source.
// The slave view belongs to cdc_handshake_tx; the master view belongs to whatever drives it.
interface cdc_handshake_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  valid_in;
    logic                  ready_out;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  req_out;
    logic                  ack_in;
    logic                  busy;
    logic                  done;

    modport master (
        output data_in,
        output valid_in,
        output ack_in,
        input  ready_out,
        input  data_out,
        input  req_out,
        input  busy,
        input  done
    );

    modport slave (
        input  data_in,
        input  valid_in,
        input  ack_in,
        output ready_out,
        output data_out,
        output req_out,
        output busy,
        output done
    );
endinterface

// File: rtl/cdc_handshake_tx.sv
// Four-phase req/ack CDC source: accepted word is held on data_out while req_out rises; done pulses SYNC_STAGES+1 edges after ack_in falls.
// ready_out is low for the whole transfer and while a stale synchronized ack is high in IDLE.
module cdc_handshake_tx #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    cdc_handshake_tx_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                  ack_s;
    logic                  req_q;
    logic                  req_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  done_q;
    logic                  done_d;
    logic                  accept;

    // Only the last stage may be observed; earlier stages can be metastable.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], bus.ack_in};
        end
    end

    assign ack_s = ack_sync[SYNC_STAGES-1];

    assign bus.ready_out = (state_q == IDLE) && !ack_s;
    assign accept        = bus.valid_in && bus.ready_out;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = bus.data_in;
                    req_d   = 1'b1;
                    state_d = REQ_HI;
                end
            end
            REQ_HI: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = REQ_LO;
                end
            end
            REQ_LO: begin
                if (!ack_s) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign bus.data_out = data_q;
    assign bus.req_out  = req_q;
    assign bus.done     = done_q;
    assign bus.busy     = (state_q != IDLE);

    // The far domain samples data_out whenever req_out is high, so it must never move between accepts.
    a_data_stable: assert property (@(posedge clk)
        (!rst && !accept) |=> (rst || $stable(bus.data_out)));

    a_req_only_in_req_hi: assert property (@(posedge clk)
        req_q |-> (state_q == REQ_HI));

    a_done_in_idle: assert property (@(posedge clk)
        done_q |-> (state_q == IDLE));

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Drives cdc_handshake_tx (SYNC_STAGES 2 and 3) with a cycle-stepped receiver and checks against edge arithmetic.
module tb_cdc_handshake_tx;

    localparam int DW = 8;
    localparam int S2 = 2;
    localparam int S3 = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cdc_handshake_tx_if #(.DATA_WIDTH(DW)) b2 ();
    cdc_handshake_tx_if #(.DATA_WIDTH(DW)) b3 ();

    cdc_handshake_tx #(.DATA_WIDTH(DW), .SYNC_STAGES(S2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (b2)
    );

    cdc_handshake_tx #(.DATA_WIDTH(DW), .SYNC_STAGES(S3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (b3)
    );

    int tests      = 0;
    int fails      = 0;
    int cyc        = 0;
    int done2_seen = 0;
    int done3_seen = 0;
    int exp_dones  = 0;
    logic [DW-1:0] exp_data;

    always @(negedge clk) begin
        if (b2.done === 1'b1) done2_seen++;
        if (b3.done === 1'b1) done3_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic in_flight(input logic exp_req);
        chk("hold_data", b2.data_out, exp_data);
        chk("req_level", b2.req_out, exp_req);
        chk("busy_high", b2.busy, 1'b1);
        chk("ready_low", b2.ready_out, 1'b0);
    endtask

    // One full four-phase transfer on the SYNC_STAGES=2 instance; returns in the done cycle.
    task automatic xfer2(input logic [DW-1:0] w, input int d1, input int d2);
        int n;
        n = 0;
        b2.valid_in = 1'b1;
        b2.data_in  = w;
        while (b2.ready_out !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("accept_ready", b2.ready_out, 1'b1);
        chk("pre_accept_hold", b2.data_out, exp_data);
        tick();
        exp_data = w;
        chk("accept_data", b2.data_out, w);
        chk("accept_req", b2.req_out, 1'b1);
        chk("accept_busy", b2.busy, 1'b1);
        b2.data_in = DW'($urandom);
        repeat (d1) begin
            tick();
            in_flight(1'b1);
            b2.data_in = DW'($urandom);
        end
        b2.ack_in = 1'b1;
        repeat (S2) begin
            tick();
            in_flight(1'b1);
        end
        tick();
        chk("req_fall", b2.req_out, 1'b0);
        in_flight(1'b0);
        repeat (d2) begin
            tick();
            in_flight(1'b0);
            b2.data_in = DW'($urandom);
        end
        b2.ack_in = 1'b0;
        repeat (S2) begin
            tick();
            in_flight(1'b0);
            chk("done_early", b2.done, 1'b0);
        end
        tick();
        chk("done_pulse", b2.done, 1'b1);
        chk("done_busy", b2.busy, 1'b0);
        chk("done_ready", b2.ready_out, 1'b1);
        chk("done_req", b2.req_out, 1'b0);
        chk("done_data", b2.data_out, exp_data);
        exp_dones++;
    endtask

    initial begin
        logic [DW-1:0] seq [3];
        logic [DW-1:0] w;
        int d1;
        int d2;
        int gap;

        seq[0] = 8'h01;
        seq[1] = 8'h02;
        seq[2] = 8'h03;

        rst         = 1'b1;
        b2.valid_in = 1'b0;
        b2.data_in  = '0;
        b2.ack_in   = 1'b0;
        b3.valid_in = 1'b0;
        b3.data_in  = '0;
        b3.ack_in   = 1'b0;
        exp_data    = '0;

        tick();
        chk("rst_req", b2.req_out, 1'b0);
        chk("rst_data", b2.data_out, 8'h00);
        chk("rst_done", b2.done, 1'b0);
        chk("rst_busy", b2.busy, 1'b0);
        chk("rst_ready", b2.ready_out, 1'b1);
        chk("rst3_req", b3.req_out, 1'b0);
        chk("rst3_ready", b3.ready_out, 1'b1);
        tick();
        rst = 1'b0;
        tick();

        // Single word with a receiver acking a few cycles after req.
        xfer2(8'hA5, 2, 2);
        b2.valid_in = 1'b0;
        tick();
        chk("single_done_clear", b2.done, 1'b0);
        chk("single_ready", b2.ready_out, 1'b1);
        chk("single_busy", b2.busy, 1'b0);
        chk("single_data", b2.data_out, 8'hA5);

        // Back-to-back with valid held high; each accept lands on the edge ending done.
        for (int i = 0; i < 3; i++) begin
            xfer2(seq[i], 1, 1);
        end
        b2.valid_in = 1'b0;
        tick();
        chk("b2b_done_clear", b2.done, 1'b0);
        chk("b2b_last_data", b2.data_out, 8'h03);

        // Randomized words, receiver delays and idle gaps.
        for (int i = 0; i < 16; i++) begin
            w   = DW'($urandom);
            d1  = int'($urandom_range(0, 4));
            d2  = int'($urandom_range(0, 4));
            gap = int'($urandom_range(0, 3));
            if (gap != 0) begin
                b2.valid_in = 1'b0;
                repeat (gap) begin
                    tick();
                    chk("idle_ready", b2.ready_out, 1'b1);
                    chk("idle_req", b2.req_out, 1'b0);
                    chk("idle_busy", b2.busy, 1'b0);
                    chk("idle_data", b2.data_out, exp_data);
                end
            end
            xfer2(w, d1, d2);
        end
        b2.valid_in = 1'b0;
        tick();
        tick();
        chk("done_count", done2_seen, exp_dones);

        // Stale ack held through reset release must block accepts until it drains.
        b2.ack_in = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        exp_data = '0;
        chk("stale_rst_data", b2.data_out, 8'h00);
        chk("stale_rst_req", b2.req_out, 1'b0);
        rst = 1'b0;
        repeat (S2) tick();
        chk("stale_ready_low", b2.ready_out, 1'b0);
        b2.valid_in = 1'b1;
        b2.data_in  = 8'h5A;
        repeat (5) begin
            tick();
            chk("stale_no_accept_ready", b2.ready_out, 1'b0);
            chk("stale_no_accept_req", b2.req_out, 1'b0);
            chk("stale_no_accept_data", b2.data_out, 8'h00);
        end
        b2.ack_in = 1'b0;
        repeat (S2 - 1) begin
            tick();
            chk("stale_drain_ready", b2.ready_out, 1'b0);
        end
        tick();
        chk("stale_ready_back", b2.ready_out, 1'b1);
        chk("stale_req_still_low", b2.req_out, 1'b0);
        chk("stale_data_still_zero", b2.data_out, 8'h00);
        xfer2(8'h5A, 1, 1);
        b2.valid_in = 1'b0;
        tick();

        // Reset while waiting for ack abandons the transfer.
        b2.valid_in = 1'b1;
        b2.data_in  = 8'h3C;
        chk("abort_ready", b2.ready_out, 1'b1);
        tick();
        exp_data = 8'h3C;
        chk("abort_data", b2.data_out, 8'h3C);
        chk("abort_req", b2.req_out, 1'b1);
        b2.valid_in = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        exp_data = '0;
        chk("abort_rst_req", b2.req_out, 1'b0);
        chk("abort_rst_data", b2.data_out, 8'h00);
        chk("abort_rst_busy", b2.busy, 1'b0);
        chk("abort_rst_done", b2.done, 1'b0);
        rst = 1'b0;
        repeat (10) begin
            tick();
            chk("abort_no_done", b2.done, 1'b0);
            chk("abort_idle_ready", b2.ready_out, 1'b1);
        end
        chk("abort_done_count", done2_seen, exp_dones);

        // Receiver that never acknowledges.
        w = DW'($urandom);
        b2.valid_in = 1'b1;
        b2.data_in  = w;
        tick();
        exp_data = w;
        repeat (1000) begin
            b2.data_in = DW'($urandom);
            tick();
            chk("noack_req", b2.req_out, 1'b1);
            chk("noack_ready", b2.ready_out, 1'b0);
            chk("noack_data", b2.data_out, exp_data);
        end
        b2.valid_in = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_data = '0;
        tick();

        // SYNC_STAGES=3: req falls exactly three edges after ack is first sampled high.
        b3.valid_in = 1'b1;
        b3.data_in  = 8'hA5;
        chk("s3_ready", b3.ready_out, 1'b1);
        tick();
        chk("s3_accept_data", b3.data_out, 8'hA5);
        chk("s3_accept_req", b3.req_out, 1'b1);
        b3.valid_in = 1'b0;
        repeat (2) tick();
        b3.ack_in = 1'b1;
        repeat (S3) begin
            tick();
            chk("s3_req_hold", b3.req_out, 1'b1);
        end
        tick();
        chk("s3_req_fall", b3.req_out, 1'b0);
        repeat (2) tick();
        b3.ack_in = 1'b0;
        repeat (S3) begin
            tick();
            chk("s3_done_early", b3.done, 1'b0);
            chk("s3_busy", b3.busy, 1'b1);
        end
        tick();
        chk("s3_done", b3.done, 1'b1);
        chk("s3_done_busy", b3.busy, 1'b0);
        chk("s3_done_ready", b3.ready_out, 1'b1);
        chk("s3_done_data", b3.data_out, 8'hA5);
        tick();
        chk("s3_done_clear", b3.done, 1'b0);
        tick();
        chk("s3_done_count", done3_seen, 1);
        chk("final_done_count", done2_seen, exp_dones);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cdc_handshake_tx.md
# cdc_handshake_tx

Source end of a four-phase req/ack clock-domain crossing. It accepts a data word from the local domain over a valid/ready handshake and presents it to a receiver in an unrelated clock domain. It holds the word stable, raises a level request and completes the transfer against an asynchronous acknowledge that it synchronizes internally with a flip-flop chain. It pairs with a receiver in the far domain that synchronizes `req_out` and returns `ack_in`.

## Interface
- `DATA_WIDTH`, 8: width of transferred word.
- `SYNC_STAGES`, 2: flip-flops in the `ack_in` synchronizer chain; legal range 2..4.

- `clk` input 1: local clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `data_in` input DATA_WIDTH: word to send; sampled on accept.
- `valid_in` input 1: `data_in` valid.
- `ready_out` output 1: block can accept; accept = `valid_in && ready_out` at a rising edge.
- `data_out` output DATA_WIDTH: registered word driven to far domain.
- `req_out` output 1: registered request level to far domain.
- `ack_in` input 1: acknowledge from far domain; asynchronous to `clk`.
- `busy` output 1: transfer in progress (state != IDLE).
- `done` output 1: one-cycle pulse when a transfer fully completes.

## Operation
- `ack_s` = last stage of a `SYNC_STAGES`-deep shift register clocked by `clk`, first stage fed by `ack_in`. Only `ack_s` is used by logic.
- FSM states:
  - IDLE:
    - `ready_out` = (`ack_s` == 0).
    - On accept: `data_out` <= `data_in`, `req_out` <= 1, go REQ_HI.
  - REQ_HI: wait for `ack_s` == 1, then `req_out` <= 0, go REQ_LO.
  - REQ_LO: wait for `ack_s` == 0, then `done` <= 1 for one cycle, go IDLE.
- `ready_out` is combinational from state and `ack_s`. It is 0 in REQ_HI and REQ_LO, and 0 in IDLE while `ack_s` is high, which covers a stale ack after reset.
- `data_out` changes only on an accept edge. It is held constant from the accept edge through the completion edge, and after it until the next accept.
- `valid_in` without `ready_out` has no effect. `data_in` is not sampled.
- No timeout. A receiver that never acknowledges leaves the block in REQ_HI indefinitely.

## Timing
- Reset values at the first edge with `rst` = 1:
  - `req_out` = 0, `data_out` = 0, `done` = 0, `busy` = 0.
  - State IDLE, all synchronizer stages 0.
  - `ready_out` = 1 the cycle after.
- Accept at edge E0: `req_out`, `data_out` and `busy` are valid after E0.
- `ack_in` rising, stable before edge Ea: `ack_s` = 1 after edge Ea+SYNC_STAGES-1, and `req_out` falls after edge Ea+SYNC_STAGES.
- `ack_in` falling, stable before edge Eb: `done` = 1 and state = IDLE after edge Eb+SYNC_STAGES.
  - `done` deasserts after the next edge.
  - `ready_out` may be 1 in the same cycle `done` is 1, so back-to-back accept is legal on the edge ending the `done` cycle.
- Minimum transfer period with an instantaneous receiver is 2·(SYNC_STAGES+1) cycles plus the receiver's own synchronizer latency.
- Reset mid-transfer: on the reset edge `req_out` and `data_out` are forced to 0 and state goes to IDLE, abandoning the transfer. A new accept is blocked until `ack_s` reads 0.
- `ack_in` glitches shorter than one `clk` period may be missed. The receiver must hold `ack_in` levels until it sees the matching `req_out` level.
- `rst` takes priority over all other events on the same edge.

## Test plan
- Reset, then `valid_in`=1, `data_in`=0xA5. Receiver model (SYNC_STAGES=2) acks 3 cycles after `req_out` rises and drops ack 3 cycles after `req_out` falls. Required: `data_out`=0xA5 held throughout, one `done` pulse, `ready_out`=1 again, `busy` low.
- Back-to-back words 0x01, 0x02, 0x03 with `valid_in` held high. Required: three `done` pulses, `data_out` sequence 0x01→0x02→0x03, each change only on an accept edge, `req_out` never high while `ack_s` is high in IDLE.
- `ack_in` held high through reset release. Required: `ready_out`=0 until `ack_in` low has propagated SYNC_STAGES edges, and `valid_in`=1 with 0x5A is not accepted early.
- Assert `rst` in REQ_HI with `data_out`=0x3C. Required: after the reset edge `req_out`=0, `data_out`=0x00, `busy`=0, `done` never pulses.
- Receiver never acks for 1000 cycles. Required: `req_out` stays 1, `ready_out` stays 0, `data_out` unchanged.
- SYNC_STAGES=3 run of the first scenario. Required: `req_out` falls exactly 3 edges after the edge at which `ack_in` is first sampled high.
